// File: rtl/scan_pkg.sv
// Shared types and constants for the scan select sequencer and its channel finder.
package scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int unsigned NCH       = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned MIN_DWELL = 1;

  // True when no enabled channel lies strictly above cur.
  function automatic logic none_above(input logic [NCH-1:0] mask, input logic [SEL_W-1:0] cur);
    none_above = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (mask[i] && (SEL_W'(i) > cur)) none_above = 1'b0;
    end
  endfunction

endpackage

// File: rtl/scan_sel_sequencer_next_ch_find.sv
// Combinational channel finder: next enabled channel above cur, and lowest enabled channel.
module next_ch_find
  import scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic [SEL_W-1:0] first
);

  // Scan from the top down so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt   = cur;
    first = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (mask[NCH-1-i]) begin
        first = SEL_W'(NCH-1-i);
        if (SEL_W'(NCH-1-i) > cur) nxt = SEL_W'(NCH-1-i);
      end
    end
  end

  assign wrap = none_above(mask, cur);

endmodule

// File: rtl/scan_sel_sequencer.sv
// Steps a 2-bit decoder select through enabled channels at a programmable dwell,
// one-shot or continuous, with start/done/err handshake and a select-valid qualifier.
module scan_sel_sequencer #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned NCH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         ch_mask,
  input  logic               pol_in,
  output logic [1:0]         sel,
  output logic               pol,
  output logic               sel_valid,
  output logic               ch_strobe,
  output logic               busy,
  output logic               done,
  output logic               err
);

  import scan_pkg::*;

  if (NCH != scan_pkg::NCH) begin : g_bad_nch
    $error("scan_sel_sequencer: NCH must be 4");
  end

  state_t             state, state_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [DWELL_W-1:0] dwell_l, dwell_d;
  logic [3:0]         mask_l, mask_d;
  logic [3:0]         find_mask;
  logic [1:0]         sel_d, cur_nxt, cur_first;
  logic               cur_wrap;
  logic               pol_d, valid_d, strobe_d, busy_d, done_d, err_d;

  // In IDLE the finder looks at the live mask so the first channel is ready at start.
  assign find_mask = (state == IDLE) ? ch_mask : mask_l;

  next_ch_find u_find (
    .mask  (find_mask),
    .cur   (sel),
    .nxt   (cur_nxt),
    .wrap  (cur_wrap),
    .first (cur_first)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    dwell_d  = dwell_l;
    mask_d   = mask_l;
    sel_d    = sel;
    pol_d    = pol;
    valid_d  = sel_valid;
    busy_d   = busy;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    unique case (state)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (!abort && start) begin
          if (ch_mask != '0) begin
            mask_d   = ch_mask;
            dwell_d  = (dwell == '0) ? DWELL_W'(MIN_DWELL) : dwell;
            pol_d    = pol_in;
            sel_d    = cur_first;
            cnt_d    = dwell_d - DWELL_W'(1);
            state_d  = SCAN;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            strobe_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt != '0) begin
          cnt_d = cnt - DWELL_W'(1);
        end else if (!cur_wrap) begin
          sel_d    = cur_nxt;
          cnt_d    = dwell_l - DWELL_W'(1);
          strobe_d = 1'b1;
        end else if (continuous) begin
          sel_d    = cur_first;
          cnt_d    = dwell_l - DWELL_W'(1);
          strobe_d = 1'b1;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // done is registered one edge early: it flags the cycle that will be the last dwell cycle of a sweep.
  assign done_d = (state_d == SCAN) && (cnt_d == '0) && none_above(mask_d, sel_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dwell_l   <= '0;
      mask_l    <= '0;
      sel       <= '0;
      pol       <= 1'b0;
      sel_valid <= 1'b0;
      ch_strobe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      dwell_l   <= dwell_d;
      mask_l    <= mask_d;
      sel       <= sel_d;
      pol       <= pol_d;
      sel_valid <= valid_d;
      ch_strobe <= strobe_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Directed self-checking bench for scan_sel_sequencer, including a behavioural decoder on its outputs.
module tb_scan_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, continuous, pol_in;
  logic [7:0] dwell;
  logic [3:0] ch_mask;
  logic [1:0] sel;
  logic       pol, sel_valid, ch_strobe, busy, done, err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  scan_sel_sequencer #(.DWELL_W(8), .NCH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .continuous (continuous),
    .dwell      (dwell),
    .ch_mask    (ch_mask),
    .pol_in     (pol_in),
    .sel        (sel),
    .pol        (pol),
    .sel_valid  (sel_valid),
    .ch_strobe  (ch_strobe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Polarity-controlled 2-to-4 decoder: A2=1 makes the selected output the only low one.
  function automatic logic [3:0] dec(input logic a2, input logic [1:0] a, input logic en);
    logic [3:0] y;
    y = '0;
    if (en) y[a] = 1'b1;
    return a2 ? ~y : y;
  endfunction

  logic [1:0] t1_sel [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    logic [3:0] ey;
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    pol_in = 1'b0; dwell = '0; ch_mask = '0;
    repeat (2) @(negedge clk);
    chk("rst_sel", sel, 0);       chk("rst_pol", pol, 0);
    chk("rst_valid", sel_valid, 0); chk("rst_strobe", ch_strobe, 0);
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // One-shot sweep; inputs changed after start must be ignored.
    ch_mask = 4'b1011; dwell = 8'd3; continuous = 1'b0; pol_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ch_mask = 4'b0000; dwell = 8'd9;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("t1_sel_c%0d", c), sel, t1_sel[c-1]);
      chk($sformatf("t1_valid_c%0d", c), sel_valid, c <= 9);
      chk($sformatf("t1_busy_c%0d", c), busy, c <= 9);
      chk($sformatf("t1_strobe_c%0d", c), ch_strobe, c == 1 || c == 4 || c == 7);
      chk($sformatf("t1_done_c%0d", c), done, c == 9);
    end
    chk("t1_pol", pol, 0);

    // Continuous, then drop continuous during the third sweep.
    ch_mask = 4'b0110; dwell = 8'd2; continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 12) chk($sformatf("t2_sel_c%0d", c), sel, (((c - 1) / 2) % 2) ? 2 : 1);
      chk($sformatf("t2_valid_c%0d", c), sel_valid, c <= 12);
      chk($sformatf("t2_strobe_c%0d", c), ch_strobe, c <= 12 && (c % 2) == 1);
      chk($sformatf("t2_done_c%0d", c), done, c <= 12 && (c % 4) == 0);
      if (c == 9) continuous = 1'b0;
    end

    // Dwell 0 on a single channel with inverted polarity.
    ch_mask = 4'b1000; dwell = 8'd0; continuous = 1'b1; pol_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("t3_sel_c%0d", c), sel, 3);
      chk($sformatf("t3_strobe_c%0d", c), ch_strobe, 1);
      chk($sformatf("t3_done_c%0d", c), done, 1);
      chk($sformatf("t3_pol_c%0d", c), pol, 1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; continuous = 1'b0;
    chk("t3_ab_valid", sel_valid, 0); chk("t3_ab_busy", busy, 0);
    chk("t3_ab_done", done, 0);       chk("t3_ab_strobe", ch_strobe, 0);
    chk("t3_ab_pol_hold", pol, 1);

    // Empty mask.
    ch_mask = 4'b0000; dwell = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_err", err, 1);   chk("t4_busy", busy, 0);
    chk("t4_valid", sel_valid, 0); chk("t4_done", done, 0);
    @(negedge clk);
    chk("t4_err_pulse", err, 0); chk("t4_busy2", busy, 0);

    // Abort mid-dwell, then restart from scratch.
    ch_mask = 4'b0110; dwell = 8'd5; pol_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_sel", sel, 1); chk("t5_strobe", ch_strobe, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_ab_valid", sel_valid, 0); chk("t5_ab_busy", busy, 0);
    chk("t5_ab_done", done, 0);       chk("t5_ab_strobe", ch_strobe, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("t5r_sel_c%0d", c), sel, (c <= 5) ? 1 : 2);
      chk($sformatf("t5r_strobe_c%0d", c), ch_strobe, c == 1 || c == 6);
      chk($sformatf("t5r_done_c%0d", c), done, 0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_ab2_busy", busy, 0);

    // Abort and start together in IDLE: no scan.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t5_as_busy", busy, 0);   chk("t5_as_valid", sel_valid, 0);
    chk("t5_as_strobe", ch_strobe, 0); chk("t5_as_err", err, 0);

    // Asynchronous reset mid-scan.
    ch_mask = 4'b1110; dwell = 8'd4; pol_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t6_pre_busy", busy, 1); chk("t6_pre_sel", sel, 1); chk("t6_pre_pol", pol, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_sel", sel, 0);   chk("t6_pol", pol, 0);
    chk("t6_valid", sel_valid, 0); chk("t6_busy", busy, 0);
    chk("t6_strobe", ch_strobe, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Decoder chain: one low output rotating Y0..Y3.
    ch_mask = 4'b1111; dwell = 8'd1; pol_in = 1'b1; continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      ey = 4'hF;
      ey[(c - 1) % 4] = 1'b0;
      chk($sformatf("t7_y_c%0d", c), dec(pol, sel, sel_valid), ey);
      chk($sformatf("t7_done_c%0d", c), done, (c % 4) == 0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; continuous = 1'b0;
    chk("t7_y_idle", dec(pol, sel, sel_valid), 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
